// File: rtl/rvx10_pkg.sv
// rvx10_pkg: types and constants shared by the RVX10 pipeline stages.
//   ctrl_t   : main decode control bundle (RegWrite is the MSB)
//   ALUOP_*  : ALU operation class driven to the EX ALU decoder
//   RES_*    : writeback result source select
//   OP_*     : RV32I major opcodes plus the CUSTOM-0 extension opcode
//   CTRL_NOP : all-zero control bundle, a side-effect-free bubble
package rvx10_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

  localparam ctrl_t CTRL_NOP = '0;

  // True when a control bundle could change architectural state.
  function automatic logic ctrl_has_effect(input ctrl_t c);
    return c.reg_write | c.mem_write | c.branch | c.jump;
  endfunction

endpackage

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr: generic W-bit pipeline register.
//   clk    : clock, rising edge
//   i_srst : synchronous active-high reset, forces zero
//   i_en   : load i_d when high
//   i_clr  : force zero; dominates i_en
//   i_d    : next value
//   o_q    : registered value
module pipe_reg_en_clr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_srst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_srst || i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register of the RVX10 core.
//   clk, reset            : clock and synchronous active-high reset
//   stall_e               : hold every EX-side output
//   flush_e               : replace the incoming instruction with a bubble
//   valid_d, ctrl_d, ...  : decoded instruction from the ID stage
//   valid_e, ctrl_e, ...  : registered copies presented to EX
//   bubble_cnt            : saturating count of bubbles written into EX
// Every output comes straight from a flop.
module id_ex_reg
  import rvx10_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  ctrl_t             ctrl_d,
  input  logic [2:0]        funct3_d,
  input  logic              funct7b5_d,
  input  logic [6:0]        opcode_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  output logic              valid_e,
  output ctrl_t             ctrl_e,
  output logic [2:0]        funct3_e,
  output logic              funct7b5_e,
  output logic [6:0]        opcode_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int CTRL_W = $bits(ctrl_t);
  localparam int DATA_W = 3 + 1 + 7 + 3 * 5 + 5 * XLEN;

  ctrl_t              w_ctrl_d;
  logic [DATA_W-1:0]  w_data_d;
  logic [DATA_W-1:0]  w_data_q;
  logic               w_load;
  logic               w_bubble;
  logic               r_valid;
  logic [CNT_W-1:0]   r_bubble_cnt;

  // A non-instruction from ID must never carry live control into EX,
  // whatever the decoder happened to leave on ctrl_d.
  assign w_ctrl_d = valid_d ? ctrl_d : CTRL_NOP;

  assign w_load   = !stall_e;
  // Newly written valid_e is 0: either flushed, or a plain load of a bubble.
  assign w_bubble = flush_e || (!stall_e && !valid_d);

  pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl_reg (
    .clk    (clk),
    .i_srst (reset),
    .i_en   (w_load),
    .i_clr  (flush_e),
    .i_d    (w_ctrl_d),
    .o_q    (ctrl_e)
  );

  // Register indices are zeroed on flush along with the rest so hazard
  // logic in EX sees x0 and never forwards from a bubble.
  assign w_data_d = {funct3_d, funct7b5_d, opcode_d, rd1_d, rd2_d,
                     rs1_d, rs2_d, rd_d, imm_ext_d, pc_d, pc_plus4_d};

  pipe_reg_en_clr #(.W(DATA_W)) u_data_reg (
    .clk    (clk),
    .i_srst (reset),
    .i_en   (w_load),
    .i_clr  (flush_e),
    .i_d    (w_data_d),
    .o_q    (w_data_q)
  );

  assign {funct3_e, funct7b5_e, opcode_e, rd1_e, rd2_e,
          rs1_e, rs2_e, rd_e, imm_ext_e, pc_e, pc_plus4_e} = w_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      if (flush_e) begin
        r_valid <= 1'b0;
      end else if (!stall_e) begin
        r_valid <= valid_d;
      end
      // Saturate rather than wrap so a long-running debug read stays sane.
      if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign valid_e    = r_valid;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register of the RVX10 5-stage core. Sits directly downstream of the ID-stage decode controller and register file.
- Captures the main control bundle, operands, immediate and PC info each cycle and presents them to EX.
- Supports stall (hold) and flush (bubble insertion).
- Keeps a saturating bubble counter for performance debug.

Parameters:
- XLEN, 32, datapath width (operands, immediate, PC).
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_e  in  1  hold all EX-side state this cycle.
- flush_e  in  1  insert a bubble into EX this cycle.
- valid_d  in  1  ID holds a real instruction.
- ctrl_d  in  ctrl_t  {RegWrite, MemWrite, MemToReg, ALUSrc, Branch, Jump, ALUOp[1:0], ResultSrc[1:0]} from the decode controller.
- funct3_d  in  3  instruction funct3.
- funct7b5_d  in  1  instruction bit 30.
- opcode_d  in  7  opcode; needed downstream for CUSTOM-0 ALU decode.
- rd1_d, rd2_d  in  XLEN  register-file read data.
- rs1_d, rs2_d, rd_d  in  5  register indices.
- imm_ext_d  in  XLEN  extended immediate.
- pc_d, pc_plus4_d  in  XLEN  PC and PC+4.
- valid_e  out  1  EX holds a real instruction.
- ctrl_e  out  ctrl_t  registered control bundle.
- funct3_e, funct7b5_e, opcode_e, rd1_e, rd2_e, rs1_e, rs2_e, rd_e, imm_ext_e, pc_e, pc_plus4_e  out  (same widths)  registered copies of the corresponding _d inputs.
- bubble_cnt  out  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Reset (reset=1 at edge): every output goes to 0, including valid_e, all ctrl_e bits, all data fields and bubble_cnt. The zeroed state is a legal bubble (no RegWrite/MemWrite/Branch/Jump).
- Per-edge priority is reset > flush_e > stall_e > load.
- Load (flush_e=0, stall_e=0):
  - Every _e register takes its _d input; latency is 1 cycle.
  - valid_e <= valid_d.
  - If valid_d=0, ctrl_e is forced to all-zero; data fields still load but are don't-care.
- Flush (flush_e=1, regardless of stall_e):
  - valid_e <= 0 and ctrl_e <= all-zero.
  - rs1_e, rs2_e, rd_e <= 0, so hazard logic never matches x0 forwarding.
  - Remaining data fields <= 0.
- Stall (stall_e=1, flush_e=0): every output holds its value, including valid_e. bubble_cnt is unchanged.
- Bubble counting:
  - bubble_cnt increments by 1 on any non-reset edge where the newly written valid_e is 0 because of a flush, or because of a load with valid_d=0.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It does not increment while stalled.
- Clean-control rule: on a bubble, none of RegWrite, MemWrite, Branch or Jump may ever be 1 at the outputs.
- Reset mid-stall or mid-flush: reset wins; the next cycle resumes normal loading.
- No combinational path from any input to any output.

Decomposition:
- rvx10_pkg holds:
  - the ctrl_t packed struct with the field order given above;
  - ALUOP_ADD=2'b00, ALUOP_BR=2'b01, ALUOP_FN=2'b10;
  - RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10;
  - the OP_* opcode constants, including OP_CUSTOM0=7'b0001011;
  - CTRL_NOP = '0.
- One natural sub-module: pipe_reg_en_clr, a generic width-parameterised flop with sync reset, enable and clear (clear dominates enable). It is instantiated for the control bundle and for the data bundle. The valid/counter logic stays in id_ex_reg.

Test Plan:
- Reset then load lw (valid_d=1, ctrl RegWrite=1, ALUSrc=1, MemToReg=1, ResultSrc=01, imm_ext_d=0x10, rs1_d=5, rd_d=7) -> the next cycle valid_e=1, ctrl_e matches, imm_ext_e=0x10, rd_e=7, bubble_cnt=0.
- Hold stall_e=1 for 3 cycles while the _d inputs change to a sw encoding -> all _e outputs keep the lw values; bubble_cnt stays 0. Deassert stall -> the sw values appear one cycle later.
- flush_e=1 with a valid R-type at _d (RegWrite=1, rd_d=3) -> valid_e=0, ctrl_e=0, rd_e=0; bubble_cnt increments to 1.
- flush_e=1 and stall_e=1 in the same cycle -> a bubble is inserted (flush wins) and bubble_cnt increments.
- valid_d=0 with ctrl_d having MemWrite=1, then Branch=1 -> ctrl_e=0 both cycles; bubble_cnt increments by 2.
- CNT_W=4, 20 consecutive flushes -> bubble_cnt=15 (saturates). Assert reset mid-sequence -> all outputs are 0 on the next cycle.
